sram_port_arbiter: RTL

- Shares one synchronous single-port SRAM between two requesters: master 0 is instruction fetch (ICache miss/refill side, read-only); master 1 is the load/store unit (read/write, byte strobes).
- Sits between the fetch and memory stages and the SRAM port.
- Valid/ready handshake on the request and response channels of each master.
- Round-robin arbitration; at most one SRAM access per cycle; each master may have one outstanding access.

---
 rtl/sram_port_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one synchronous single-port SRAM between the
// instruction-fetch master (m0, read-only) and the load/store master (m1,
// byte-strobed writes). One SRAM access per cycle, round-robin between the
// two masters, and at most one outstanding access per master. Read data
// flows straight from the SRAM to the requester in the cycle after the
// access. If the consumer stalls, the response is parked in a per-master
// holding register until it is taken.
module sram_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  m0_req_valid,
  output logic                  m0_req_ready,
  input  logic [ADDR_W-1:0]     m0_req_addr,
  output logic                  m0_resp_valid,
  output logic [DATA_W-1:0]     m0_resp_data,
  input  logic                  m0_resp_ready,

  input  logic                  m1_req_valid,
  output logic                  m1_req_ready,
  input  logic [DATA_W/8-1:0]   m1_req_we,
  input  logic [ADDR_W-1:0]     m1_req_addr,
  input  logic [DATA_W-1:0]     m1_req_wdata,
  output logic                  m1_resp_valid,
  output logic [DATA_W-1:0]     m1_resp_data,
  input  logic                  m1_resp_ready,

  output logic                  sram_en,
  output logic [DATA_W/8-1:0]   sram_we,
  output logic [ADDR_W-1:0]     sram_addr,
  output logic [DATA_W-1:0]     sram_wdata,
  input  logic [DATA_W-1:0]     sram_rdata
);

  localparam int BE_W = DATA_W / 8;

  // Which master received the most recent grant. On a tie, the other master wins.
  typedef enum logic {
    OWNER_M0 = 1'b0,
    OWNER_M1 = 1'b1
  } owner_t;

  owner_t            last_grant;

  // An access issued last cycle whose data is on sram_rdata this cycle.
  logic              inflight0;
  logic              inflight1;
  logic              inflight_we;

  // Responses parked because the consumer was not ready.
  logic              hold_valid0;
  logic              hold_valid1;
  logic [DATA_W-1:0] hold_data0;
  logic [DATA_W-1:0] hold_data1;

  logic              elig0;
  logic              elig1;
  logic              cand0;
  logic              cand1;
  logic              grant0;
  logic              grant1;

  logic [DATA_W-1:0] flow_data0;
  logic [DATA_W-1:0] flow_data1;

  // A master may issue when its previous response is either gone or being consumed right now.
  always_comb begin
    elig0  = !hold_valid0 && !(inflight0 && !m0_resp_ready);
    elig1  = !hold_valid1 && !(inflight1 && !m1_resp_ready);
    cand0  = !rst && m0_req_valid && elig0;
    cand1  = !rst && m1_req_valid && elig1;
    grant0 = cand0 && (!cand1 || (last_grant == OWNER_M1));
    grant1 = cand1 && (!cand0 || (last_grant == OWNER_M0));
  end

  // Drive the SRAM port from the granted master. All fields are zero when the port is idle.
  always_comb begin
    m0_req_ready = grant0;
    m1_req_ready = grant1;
    sram_en      = grant0 || grant1;
    sram_we      = '0;
    sram_addr    = '0;
    sram_wdata   = '0;
    if (grant0) begin
      sram_addr = m0_req_addr;
    end else if (grant1) begin
      sram_addr  = m1_req_addr;
      sram_we    = m1_req_we;
      sram_wdata = m1_req_wdata;
    end
  end

  // Present each master's response. A held response takes precedence over flow-through data.
  always_comb begin
    flow_data0    = sram_rdata;
    flow_data1    = inflight_we ? '0 : sram_rdata;
    m0_resp_valid = !rst && (hold_valid0 || inflight0);
    m1_resp_valid = !rst && (hold_valid1 || inflight1);
    m0_resp_data  = '0;
    m1_resp_data  = '0;
    if (hold_valid0) begin
      m0_resp_data = hold_data0;
    end else if (inflight0) begin
      m0_resp_data = flow_data0;
    end
    if (hold_valid1) begin
      m1_resp_data = hold_data1;
    end else if (inflight1) begin
      m1_resp_data = flow_data1;
    end
  end

  // Track issued accesses and the round-robin pointer. Reset drops any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight0   <= 1'b0;
      inflight1   <= 1'b0;
      inflight_we <= 1'b0;
      last_grant  <= OWNER_M1;
    end else begin
      inflight0   <= grant0;
      inflight1   <= grant1;
      inflight_we <= grant1 && (m1_req_we != {BE_W{1'b0}});
      if (grant0) begin
        last_grant <= OWNER_M0;
      end else if (grant1) begin
        last_grant <= OWNER_M1;
      end
    end
  end

  // Park the fetch response when its consumer stalls, and release it on handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid0 <= 1'b0;
      hold_data0  <= '0;
    end else if (hold_valid0) begin
      if (m0_resp_ready) begin
        hold_valid0 <= 1'b0;
      end
    end else if (inflight0 && !m0_resp_ready) begin
      hold_valid0 <= 1'b1;
      hold_data0  <= flow_data0;
    end
  end

  // Park the load/store response when its consumer stalls, and release it on handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid1 <= 1'b0;
      hold_data1  <= '0;
    end else if (hold_valid1) begin
      if (m1_resp_ready) begin
        hold_valid1 <= 1'b0;
      end
    end else if (inflight1 && !m1_resp_ready) begin
      hold_valid1 <= 1'b1;
      hold_data1  <= flow_data1;
    end
  end

endmodule
